// File: rtl/rahbit_packet_arbiter.sv
// rahbit_packet_arbiter: shares the 48-bit collector packet bus between the
// float source (app=01) and the fixed-point source (app=10). Each accepted
// transaction becomes one or two bus words; words are separated by an
// all-zero cycle and each transaction is followed by GAP_CYCLES idle cycles.
module rahbit_packet_arbiter #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        f_valid,
  input  logic [2:0]  f_size,
  input  logic [79:0] f_payload,
  output logic        f_ack,
  input  logic        x_valid,
  input  logic [2:0]  x_size,
  input  logic [79:0] x_payload,
  output logic        x_ack,
  output logic [47:0] dataout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        drop_err
);

  typedef enum logic [1:0] {IDLE, WORD1, WORD2, GAP} state_t;

  localparam logic [1:0] APP_FLOAT = 2'b01;
  localparam logic [1:0] APP_FIXED = 2'b10;
  localparam logic [2:0] PKT_ONLY  = 3'b000;
  localparam logic [2:0] PKT_FIRST = 3'b001;
  localparam logic [2:0] PKT_SECOND = 3'b010;
  localparam logic [3:0] GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  // Where a finished transaction goes: no gap state at all when GAP_CYCLES=0.
  localparam state_t     END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t      state, state_nxt;
  logic        rr_last, rr_last_nxt;        // 1 = fixed was granted last
  logic [3:0]  gap_cnt, gap_cnt_nxt;
  logic [47:0] dataout_nxt;
  logic        out_valid_nxt, f_ack_nxt, x_ack_nxt, drop_err_nxt, busy_nxt;
  logic        grant_f, grant_x;
  logic [1:0]  lat_app;
  logic [2:0]  lat_size;
  logic [79:0] lat_payload;
  logic        single_word;

  function automatic logic size_legal(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
  endfunction

  function automatic logic [47:0] make_word(input logic [1:0] app, input logic [2:0] size,
                                            input logic [2:0] pkt, input logic [39:0] data);
    return {app, size, pkt, data};
  endfunction

  assign single_word = (lat_size == 3'd1);

  // Arbitration: lone requester wins; on a tie the source not granted last wins.
  always_comb begin
    grant_f = 1'b0;
    grant_x = 1'b0;
    if (state == IDLE) begin
      if (f_valid && x_valid) begin
        grant_f = rr_last;
        grant_x = !rr_last;
      end else if (f_valid) begin
        grant_f = 1'b1;
      end else if (x_valid) begin
        grant_x = 1'b1;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt     = state;
    rr_last_nxt   = rr_last;
    gap_cnt_nxt   = gap_cnt;
    dataout_nxt   = dataout;
    out_valid_nxt = out_valid;
    f_ack_nxt     = 1'b0;
    x_ack_nxt     = 1'b0;
    drop_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_f || grant_x) begin
          state_nxt   = WORD1;
          rr_last_nxt = grant_x;
        end
      end
      WORD1: begin
        if (!out_valid) begin
          // First cycle after the grant: acknowledge and either emit or drop.
          f_ack_nxt = (lat_app == APP_FLOAT);
          x_ack_nxt = (lat_app == APP_FIXED);
          if (!size_legal(lat_size)) begin
            drop_err_nxt = 1'b1;
            state_nxt    = END_STATE;
            gap_cnt_nxt  = 4'd0;
          end else begin
            out_valid_nxt = 1'b1;
            dataout_nxt   = single_word
                          ? make_word(lat_app, lat_size, PKT_ONLY, lat_payload[39:0])
                          : make_word(lat_app, lat_size, PKT_FIRST, lat_payload[79:40]);
          end
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          dataout_nxt   = '0;
          gap_cnt_nxt   = 4'd0;
          state_nxt     = single_word ? END_STATE : WORD2;
        end
      end
      WORD2: begin
        if (!out_valid) begin
          out_valid_nxt = 1'b1;
          dataout_nxt   = make_word(lat_app, lat_size, PKT_SECOND, lat_payload[39:0]);
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          dataout_nxt   = '0;
          gap_cnt_nxt   = 4'd0;
          state_nxt     = END_STATE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Control and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      gap_cnt   <= 4'd0;
      dataout   <= '0;
      out_valid <= 1'b0;
      f_ack     <= 1'b0;
      x_ack     <= 1'b0;
      drop_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_last_nxt;
      gap_cnt   <= gap_cnt_nxt;
      dataout   <= dataout_nxt;
      out_valid <= out_valid_nxt;
      f_ack     <= f_ack_nxt;
      x_ack     <= x_ack_nxt;
      drop_err  <= drop_err_nxt;
      busy      <= busy_nxt;
    end
  end

  // Transaction latch: captured on grant, only read while a transaction is active.
  always_ff @(posedge clk) begin
    if (grant_f) begin
      lat_app     <= APP_FLOAT;
      lat_size    <= f_size;
      lat_payload <= f_payload;
    end else if (grant_x) begin
      lat_app     <= APP_FIXED;
      lat_size    <= x_size;
      lat_payload <= x_payload;
    end
  end

endmodule

// File: tb/tb_rahbit_packet_arbiter.sv
// Directed bench for rahbit_packet_arbiter (GAP_CYCLES=1): a per-cycle vector
// table for single transactions plus hand sequences for round-robin,
// back-pressure and mid-transaction reset.
module tb_rahbit_packet_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        f_valid, x_valid, out_ready;
  logic [2:0]  f_size, x_size;
  logic [79:0] f_payload, x_payload;
  logic        f_ack, x_ack, out_valid, busy, drop_err;
  logic [47:0] dataout;

  int n_vec = 0;
  int n_err = 0;

  rahbit_packet_arbiter #(.GAP_CYCLES(1)) dut (
    .clk(clk), .rstn(rstn),
    .f_valid(f_valid), .f_size(f_size), .f_payload(f_payload), .f_ack(f_ack),
    .x_valid(x_valid), .x_size(x_size), .x_payload(x_payload), .x_ack(x_ack),
    .dataout(dataout), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        fv;
    logic [2:0]  fs;
    logic [79:0] fp;
    logic        xv;
    logic [2:0]  xs;
    logic [79:0] xp;
    logic        rdy;
    logic [47:0] d;
    logic        ov, fa, xa, bz, de;
  } vec_t;

  vec_t vecs[$];

  localparam logic [79:0] P_F1 = {40'h00_0000_0000, 40'h12_3456_7800};
  localparam logic [79:0] P_X3 = {40'hAA_AAAA_AAAA, 40'h55_5555_5555};
  localparam logic [79:0] P_FR = {40'h11_1111_1111, 40'h22_2222_2222};
  localparam logic [79:0] P_XR = {40'h33_3333_3333, 40'h44_4444_4444};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [47:0] d, input logic ov, input logic fa,
                     input logic xa, input logic bz, input logic de);
    n_vec++;
    if ({dataout, out_valid, f_ack, x_ack, busy, drop_err} !== {d, ov, fa, xa, bz, de}) begin
      n_err++;
      $display("FAIL %s: got d=%h ov=%b fa=%b xa=%b busy=%b de=%b, want d=%h ov=%b fa=%b xa=%b busy=%b de=%b",
               nm, dataout, out_valid, f_ack, x_ack, busy, drop_err, d, ov, fa, xa, bz, de);
    end
  endtask

  task automatic cmp(input string nm, input logic [47:0] got, input logic [47:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic idle_inputs();
    f_valid = 0; f_size = 0; f_payload = '0;
    x_valid = 0; x_size = 0; x_payload = '0;
    out_ready = 1;
  endtask

  task automatic do_reset();
    rstn = 0;
    step();
    step();
    chk("reset", 48'h0, 0, 0, 0, 0, 0);
    rstn = 1;
  endtask

  task automatic addv(input string nm, input logic fv, input logic [2:0] fs, input logic [79:0] fp,
                      input logic xv, input logic [2:0] xs, input logic [79:0] xp, input logic rdy,
                      input logic [47:0] d, input logic ov, input logic fa, input logic xa,
                      input logic bz, input logic de);
    vec_t v;
    v.name = nm; v.fv = fv; v.fs = fs; v.fp = fp; v.xv = xv; v.xs = xs; v.xp = xp; v.rdy = rdy;
    v.d = d; v.ov = ov; v.fa = fa; v.xa = xa; v.bz = bz; v.de = de;
    vecs.push_back(v);
  endtask

  logic [47:0] rr_words[8];
  logic [1:0]  rr_acks[4];

  initial begin
    idle_inputs();
    rstn = 0;

    // Expected values are the registered outputs after the edge that follows each vector.
    addv("f1_grant", 1, 3'd1, P_F1, 0, 0, '0, 1, 48'h0,             0, 0, 0, 1, 0);
    addv("f1_word",  1, 3'd1, P_F1, 0, 0, '0, 1, 48'h4812_3456_7800, 1, 1, 0, 1, 0);
    addv("f1_gap",   0, 3'd0, '0,   0, 0, '0, 1, 48'h0,             0, 0, 0, 1, 0);
    addv("f1_idle",  0, 3'd0, '0,   0, 0, '0, 1, 48'h0,             0, 0, 0, 0, 0);
    addv("x3_grant", 0, 0, '0, 1, 3'd3, P_X3, 1, 48'h0,             0, 0, 0, 1, 0);
    addv("x3_w1",    0, 0, '0, 1, 3'd3, P_X3, 1, 48'h99AA_AAAA_AAAA, 1, 0, 1, 1, 0);
    addv("x3_zero",  0, 0, '0, 0, 3'd0, '0,   1, 48'h0,             0, 0, 0, 1, 0);
    addv("x3_w2",    0, 0, '0, 0, 3'd0, '0,   1, 48'h9A55_5555_5555, 1, 0, 0, 1, 0);
    addv("x3_gap",   0, 0, '0, 0, 3'd0, '0,   1, 48'h0,             0, 0, 0, 1, 0);
    addv("x3_idle",  0, 0, '0, 0, 3'd0, '0,   1, 48'h0,             0, 0, 0, 0, 0);
    addv("x5_grant", 0, 0, '0, 1, 3'd5, P_X3, 1, 48'h0,             0, 0, 0, 1, 0);
    addv("x5_drop",  0, 0, '0, 1, 3'd5, P_X3, 1, 48'h0,             0, 0, 1, 1, 1);
    addv("x5_gap",   0, 0, '0, 0, 3'd0, '0,   1, 48'h0,             0, 0, 0, 0, 0);
    addv("x5_idle",  0, 0, '0, 0, 3'd0, '0,   1, 48'h0,             0, 0, 0, 0, 0);
    addv("f0_grant", 1, 3'd0, P_F1, 0, 0, '0, 1, 48'h0,             0, 0, 0, 1, 0);
    addv("f0_drop",  1, 3'd0, P_F1, 0, 0, '0, 1, 48'h0,             0, 1, 0, 1, 1);
    addv("f0_idle",  0, 3'd0, '0,   0, 0, '0, 1, 48'h0,             0, 0, 0, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      f_valid = vecs[i].fv; f_size = vecs[i].fs; f_payload = vecs[i].fp;
      x_valid = vecs[i].xv; x_size = vecs[i].xs; x_payload = vecs[i].xp;
      out_ready = vecs[i].rdy;
      step();
      chk(vecs[i].name, vecs[i].d, vecs[i].ov, vecs[i].fa, vecs[i].xa, vecs[i].bz, vecs[i].de);
    end

    // Round-robin: both sources valid from reset with size=2, four transactions.
    rr_words = '{48'h5111_1111_1111, 48'h5222_2222_2222, 48'h9133_3333_3333, 48'h9244_4444_4444,
                 48'h5111_1111_1111, 48'h5222_2222_2222, 48'h9133_3333_3333, 48'h9244_4444_4444};
    rr_acks  = '{2'b10, 2'b01, 2'b10, 2'b01};
    idle_inputs();
    f_valid = 1; f_size = 3'd2; f_payload = P_FR;
    x_valid = 1; x_size = 3'd2; x_payload = P_XR;
    do_reset();
    begin
      int wi = 0;
      int ai = 0;
      for (int c = 0; c < 80 && wi < 8; c++) begin
        step();
        if (f_ack || x_ack) begin
          if (ai < 4) cmp("rr_ack_order", {46'h0, f_ack, x_ack}, {46'h0, rr_acks[ai]});
          else cmp("rr_extra_ack", {46'h0, f_ack, x_ack}, 48'h0);
          ai++;
          if (ai == 4) begin
            f_valid = 0;
            x_valid = 0;
          end
        end
        if (out_valid) begin
          cmp("rr_word", dataout, rr_words[wi]);
          wi++;
        end
      end
      cmp("rr_word_count", 48'(wi), 48'd8);
      cmp("rr_ack_count", 48'(ai), 48'd4);
    end
    step();
    step();
    chk("rr_idle", 48'h0, 0, 0, 0, 0, 0);

    // Back-pressure: WORD1 held for four cycles, WORD2 only after its handshake.
    idle_inputs();
    do_reset();
    f_valid = 1; f_size = 3'd2; f_payload = P_FR; out_ready = 0;
    step();
    chk("bp_grant", 48'h0, 0, 0, 0, 1, 0);
    step();
    chk("bp_w1", 48'h5111_1111_1111, 1, 1, 0, 1, 0);
    f_valid = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_w1_hold", 48'h5111_1111_1111, 1, 0, 0, 1, 0);
    end
    out_ready = 1;
    step();
    chk("bp_zero", 48'h0, 0, 0, 0, 1, 0);
    step();
    chk("bp_w2", 48'h5222_2222_2222, 1, 0, 0, 1, 0);
    step();
    chk("bp_after_w2", 48'h0, 0, 0, 0, 1, 0);
    step();
    chk("bp_idle", 48'h0, 0, 0, 0, 0, 0);

    // Reset while WORD1 is live: bus clears at once, WORD2 never appears, float wins next tie.
    idle_inputs();
    do_reset();
    f_valid = 1; f_size = 3'd2; f_payload = P_FR; out_ready = 0;
    step();
    step();
    chk("rst_w1", 48'h5111_1111_1111, 1, 1, 0, 1, 0);
    f_valid = 0;
    out_ready = 1;
    rstn = 0;
    #1;
    chk("rst_async_clear", 48'h0, 0, 0, 0, 0, 0);
    step();
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_no_word", 48'h0, 0, 0, 0, 0, 0);
    end
    f_valid = 1; f_size = 3'd1; f_payload = P_F1;
    x_valid = 1; x_size = 3'd1; x_payload = P_X3;
    step();
    chk("rst_regrant", 48'h0, 0, 0, 0, 1, 0);
    step();
    chk("rst_float_first", 48'h4812_3456_7800, 1, 1, 0, 1, 0);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rahbit_packet_arbiter.md
Name: rahbit_packet_arbiter

Overview:
- Shares the single 48-bit packet bus that feeds the downstream packet collector between two application sources: floating-point (app=01) and fixed-point int/frac (app=10).
- Accepts whole transactions from each source and serializes each into 1 or 2 bus words of the form app[47:46], size[45:43], packet[42:40], data[39:0].
- Multi-word transactions are never interleaved with the other source's words.
- Between words the bus drives all-zero, so app=00 makes the collector drop its enables.

Parameters:
- GAP_CYCLES, 1, number of all-zero idle cycles inserted after every completed transaction (0..15).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- f_valid  in  1  float source has a transaction pending.
- f_size  in  3  float transaction size code (1, 2 or 3).
- f_payload  in  80  float transaction payload.
- f_ack  out  1  one-cycle pulse: float transaction accepted.
- x_valid  in  1  fixed source has a transaction pending.
- x_size  in  3  fixed transaction size code.
- x_payload  in  80  fixed transaction payload.
- x_ack  out  1  one-cycle pulse: fixed transaction accepted.
- dataout  out  48  packet word to the collector.
- out_valid  out  1  dataout holds a live word.
- out_ready  in  1  downstream consumes the word this cycle.
- busy  out  1  state is not IDLE.
- drop_err  out  1  one-cycle pulse: a transaction with an illegal size code was dropped.

Behaviour:
- Reset (async, rstn=0): state=IDLE; dataout=0, out_valid=0, f_ack=0, x_ack=0, busy=0, drop_err=0; rr_last=fixed, so float wins the first tie. All outputs are registered.
- States: IDLE, WORD1, WORD2, GAP.
- IDLE, arbitration:
  - Only one valid: grant that source.
  - Both valid: grant the source not equal to rr_last.
  - On grant, latch app/size/payload, set rr_last, and pulse that source's ack next cycle.
  - Requester holds valid/size/payload stable until its ack, then may drop or change them.
- Legal size=1 -> WORD1, one word: packet=000, data=payload[39:0].
- Legal size=2 or 3 -> WORD1 then WORD2:
  - WORD1: packet=001, data=payload[79:40].
  - WORD2: packet=010, data=payload[39:0].
- Illegal size (0, 4-7): ack and drop_err pulse in the same cycle; no bus word; go to GAP (or IDLE if GAP_CYCLES=0).
- Latency: valid sampled at edge N. Ack and the first word (out_valid=1) appear after edge N+1.
- Word handshake:
  - A word holds unchanged while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, the next word appears on the following cycle.
  - After the last word: dataout=0, out_valid=0, enter GAP.
- GAP: counts GAP_CYCLES cycles with dataout=0, then returns to IDLE. With GAP_CYCLES=0, go straight to IDLE. IDLE grants no earlier than the cycle after re-entry.
- Word cadence: two consecutive words are always separated by at least one out_valid=0 cycle with dataout=0. The word after WORD1 is handshaked therefore appears 2 cycles later. The collector must never see a repeated live word.
- Arbitration lock: requests arriving while busy wait; they are never lost and never preempt.
- Round-robin fairness: with both sources continuously valid, grants strictly alternate.
- Reset mid-transaction: the transaction is abandoned, the bus returns to 0 immediately, and no further ack or word is issued.
- busy = (state != IDLE).

Test Plan:
- Float size=1, f_payload[39:0]=40'h12_3456_7800, out_ready=1 -> f_ack pulse; one word 48'h4812_3456_7800 (app=01, size=001, packet=000); then dataout=0 for GAP_CYCLES.
- Fixed size=3, payload=80'hAAAAAAAAAA_5555555555 -> word 48'h99AA_AAAA_AAAA (app=10, size=011, packet=001); one zero cycle; word 48'h9A55_5555_5555; x_ack pulses exactly once.
- f_valid and x_valid both asserted from reset, size=2 each, held through 4 transactions -> grant order float, fixed, float, fixed; no interleaving of words.
- Float size=2 with out_ready=0 for 3 cycles during WORD1 -> WORD1 held stable 4 cycles; WORD2 issued only after the handshake; no word duplicated.
- x_size=5 -> x_ack and drop_err pulse together; no out_valid; arbiter returns to IDLE after GAP.
- rstn deasserted for 1 cycle between WORD1 and WORD2 -> dataout=0, out_valid=0 immediately; WORD2 never emitted; next grant goes to float.
